// File: rtl/mips_mult_pkg.sv
// Shared constants and tracker entry type for the HI/LO multiply unit.
// Imported by mult_track_pipe and mult_hilo_ctrl.
package mips_mult_pkg;

  localparam int MUL_LAT_DEF = 3;
  localparam int DW_DEF      = 32;
  localparam int HILO_W      = 64;

  typedef struct packed {
    logic valid;
    logic madd;
  } trk_t;

endpackage

// File: rtl/mult_track_pipe.sv
// Valid/tag delay line following products through the multiplier.
// Ports: clk, rst (async high), din (entry in), tail (oldest entry), busy.
module mult_track_pipe
  import mips_mult_pkg::*;
#(
  parameter int DEPTH = MUL_LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst,
  input  trk_t din,
  output trk_t tail,
  output logic busy
);

  trk_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], din};
    end
  end

  assign tail = pipe[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Issue/writeback around a 16x16 pipelined signed multiplier with HI/LO.
// Ports: clk, rst, mult_start, rs_data, rt_data, mul_a/mul_b/mul_p,
//   mf_hi_req, mf_lo_req, mt_hi, mt_lo, mt_data, rdata, rdata_valid,
//   stall, busy, hi, lo. Macro MULT_MADD_EN adds input madd.
module mult_hilo_ctrl
  import mips_mult_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mult_start,
  input  logic [31:0]   rs_data,
  input  logic [31:0]   rt_data,
  output logic [15:0]   mul_a,
  output logic [15:0]   mul_b,
  input  logic [31:0]   mul_p,
  input  logic          mf_hi_req,
  input  logic          mf_lo_req,
  input  logic          mt_hi,
  input  logic          mt_lo,
  input  logic [DW-1:0] mt_data,
`ifdef MULT_MADD_EN
  input  logic          madd,
`endif
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          stall,
  output logic          busy,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  trk_t            din;
  trk_t            tail;
  logic            req_any;
  logic            accept_mul;
  logic            idle;
  logic [2*DW-1:0] p_ext;
  logic [2*DW-1:0] hilo_sum;
  logic            unused_hi_bits;

  assign unused_hi_bits = ^{rs_data[31:16], rt_data[31:16]};

  assign req_any    = mf_hi_req | mf_lo_req | mt_hi | mt_lo;
  assign stall      = req_any & busy;
  assign accept_mul = mult_start & ~stall;
  assign idle       = ~busy;

  assign p_ext    = {{(2*DW-32){mul_p[31]}}, mul_p};
  assign hilo_sum = {hi, lo} + p_ext;

  always_comb begin
    din       = '0;
    din.valid = accept_mul;
`ifdef MULT_MADD_EN
    din.madd  = accept_mul & madd;
`endif
  end

  // Depth is one more than the multiplier latency: the operand
  // register here is the multiplier's first input stage.
  mult_track_pipe #(
    .DEPTH(MUL_LAT + 1)
  ) u_track (
    .clk (clk),
    .rst (rst),
    .din (din),
    .tail(tail),
    .busy(busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a       <= '0;
      mul_b       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      rdata_valid <= 1'b0;
      if (accept_mul) begin
        mul_a <= rs_data[15:0];
        mul_b <= rt_data[15:0];
      end
      // MF samples hi/lo before any MT in the same cycle lands.
      if (idle & (mf_hi_req | mf_lo_req)) begin
        rdata       <= mf_hi_req ? hi : lo;
        rdata_valid <= 1'b1;
      end
      // Writeback and MT never coincide: MT needs busy low,
      // a live tail bit keeps busy high.
      if (tail.valid) begin
        {hi, lo} <= tail.madd ? hilo_sum : p_ext;
      end else begin
        if (idle & mt_hi) hi <= mt_data;
        if (idle & mt_lo) lo <= mt_data;
      end
    end
  end

endmodule
